// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and default sizes for the tpu_gemm engine
package tpu_pkg;

  localparam int ARRAY_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  localparam int IDX_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tpu_gemm_if.sv
// rtl/tpu_gemm_if.sv - start handshake plus A/B/C buffer ports of the GEMM engine
interface tpu_gemm_if
  import tpu_pkg::*;
#(
  parameter int ARRAY  = ARRAY_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
);

  logic                    in_valid;
  logic [7:0]              K;
  logic [7:0]              M;
  logic [7:0]              N;
  logic                    is_signed;
  logic                    busy;

  logic                    A_wr_en;
  logic [IDX_W-1:0]        A_index;
  logic [ARRAY*DATA_W-1:0] A_data_in;
  logic [ARRAY*DATA_W-1:0] A_data_out;

  logic                    B_wr_en;
  logic [IDX_W-1:0]        B_index;
  logic [ARRAY*DATA_W-1:0] B_data_in;
  logic [ARRAY*DATA_W-1:0] B_data_out;

  logic                    C_wr_en;
  logic [IDX_W-1:0]        C_index;
  logic [ARRAY*ACC_W-1:0]  C_data_in;
  logic [ARRAY*ACC_W-1:0]  C_data_out;

  // Engine side: drives the buffer ports and busy.
  modport master (
    input  in_valid, K, M, N, is_signed,
    output busy,
    output A_wr_en, A_index, A_data_in,
    input  A_data_out,
    output B_wr_en, B_index, B_data_in,
    input  B_data_out,
    output C_wr_en, C_index, C_data_in,
    input  C_data_out
  );

  // Host side: starts jobs and owns the buffers.
  modport slave (
    output in_valid, K, M, N, is_signed,
    input  busy,
    input  A_wr_en, A_index, A_data_in,
    output A_data_out,
    input  B_wr_en, B_index, B_data_in,
    output B_data_out,
    input  C_wr_en, C_index, C_data_in,
    output C_data_out
  );

endinterface

// File: rtl/tpu_mac_array.sv
// rtl/tpu_mac_array.sv - ARRAY x ARRAY output-stationary accumulator grid with row readout
module tpu_mac_array
  import tpu_pkg::*;
#(
  parameter int ARRAY  = ARRAY_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic                       en_i,
  input  logic                       is_signed_i,
  input  logic [ARRAY*DATA_W-1:0]    a_i,
  input  logic [ARRAY*DATA_W-1:0]    b_i,
  input  logic [$clog2(ARRAY)-1:0]   row_sel_i,
  output logic [ARRAY*ACC_W-1:0]     row_o
);

  localparam int PW = 2 * DATA_W + 2;

  // Next-state view of every accumulator; reading this (not the register)
  // lets row 0 be captured on the same edge that absorbs the last product.
  logic [ARRAY*ARRAY*ACC_W-1:0] acc_flat;

  for (genvar gi = 0; gi < ARRAY; gi++) begin : g_row
    for (genvar gj = 0; gj < ARRAY; gj++) begin : g_col
      logic signed [DATA_W:0]  a_ext;
      logic signed [DATA_W:0]  b_ext;
      logic signed [PW-1:0]    prod;
      logic [ACC_W-1:0]        prod_ext;
      logic [ACC_W-1:0]        acc_q;
      logic [ACC_W-1:0]        acc_d;

      // Lane 0 sits in the MSBs; one extra bit carries sign or zero extension.
      assign a_ext    = {is_signed_i & a_i[(ARRAY-gi)*DATA_W-1], a_i[(ARRAY-1-gi)*DATA_W +: DATA_W]};
      assign b_ext    = {is_signed_i & b_i[(ARRAY-gj)*DATA_W-1], b_i[(ARRAY-1-gj)*DATA_W +: DATA_W]};
      assign prod     = a_ext * b_ext;
      assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
      assign acc_d    = !en_i  ? acc_q :
                        load_i ? prod_ext :
                                 acc_q + prod_ext;
      assign acc_flat[(gi*ARRAY+gj)*ACC_W +: ACC_W] = acc_d;

      // Accumulator register; the k=0 product overwrites instead of adding.
      always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
      end
    end
  end

  // Select one accumulator row, column 0 in the MSBs.
  always_comb begin
    row_o = '0;
    for (int j = 0; j < ARRAY; j++) begin
      row_o[(ARRAY-1-j)*ACC_W +: ACC_W] = acc_flat[(int'(row_sel_i)*ARRAY + j)*ACC_W +: ACC_W];
    end
  end

endmodule

// File: rtl/tpu_gemm.sv
// rtl/tpu_gemm.sv - tiled GEMM engine: sequencing FSM, buffer addressing and C writeback
module tpu_gemm
  import tpu_pkg::*;
#(
  parameter int ARRAY  = ARRAY_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input logic        clk,
  input logic        rst,
  tpu_gemm_if.master bus
);

  localparam int RW = $clog2(ARRAY);

  state_e           state_q, state_d;
  logic [7:0]       k_q, k_d;
  logic [RW-1:0]    r_q, r_d;
  logic [7:0]       mt_q, mt_d;
  logic [7:0]       nt_q, nt_d;
  logic [7:0]       k_lat_q, m_lat_q, n_lat_q;
  logic             sgn_q;
  logic             en_q, load_q;

  logic             busy_q, busy_d;
  logic [IDX_W-1:0] a_index_q, a_index_d;
  logic [IDX_W-1:0] b_index_q, b_index_d;
  logic             c_wr_en_q, c_wr_en_d;
  logic [IDX_W-1:0] c_index_q, c_index_d;
  logic [ARRAY*ACC_W-1:0] c_data_q, c_data_d;
  logic [ARRAY*ACC_W-1:0] row_data;

  logic [IDX_W-1:0] mt_base, nt_base;
  logic             last_row, last_nt, last_mt;
  logic [7:0]       k_len, m_len;
  logic             unused_c_data;

  assign unused_c_data = ^bus.C_data_out;

  assign mt_base  = IDX_W'(mt_q) * IDX_W'(ARRAY);
  assign nt_base  = IDX_W'(nt_q) * IDX_W'(ARRAY);
  assign last_row = (r_q == RW'(ARRAY-1)) ||
                    (mt_base + IDX_W'(r_q) + IDX_W'(1) >= IDX_W'(m_lat_q));
  assign last_nt  = (nt_base + IDX_W'(ARRAY) >= IDX_W'(n_lat_q));
  assign last_mt  = (mt_base + IDX_W'(ARRAY) >= IDX_W'(m_lat_q));

  // Dimensions are being latched on the start edge, so use the live ones there.
  assign k_len = (state_q == IDLE) ? bus.K : k_lat_q;
  assign m_len = (state_q == IDLE) ? bus.M : m_lat_q;

  // State, counters, latched job parameters and the read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      mt_q    <= '0;
      nt_q    <= '0;
      k_lat_q <= '0;
      m_lat_q <= '0;
      n_lat_q <= '0;
      sgn_q   <= 1'b0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      mt_q    <= mt_d;
      nt_q    <= nt_d;
      if (state_q == IDLE && bus.in_valid) begin
        k_lat_q <= bus.K;
        m_lat_q <= bus.M;
        n_lat_q <= bus.N;
        sgn_q   <= bus.is_signed;
      end
      // A read issued this cycle returns next cycle, so the MAC enable lags by one.
      en_q   <= (state_q == LOAD);
      load_q <= (state_q == LOAD) && (k_q == 8'd0);
    end
  end

  // Next-state and counter sequencing: mt outer, nt inner.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    mt_d    = mt_q;
    nt_d    = nt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          k_d  = '0;
          r_d  = '0;
          mt_d = '0;
          nt_d = '0;
          if (bus.K == 8'd0 || bus.M == 8'd0 || bus.N == 8'd0) state_d = DONE;
          else                                                 state_d = LOAD;
        end
      end
      LOAD: begin
        if (k_q == k_lat_q - 8'd1) state_d = DRAIN;
        else                       k_d     = k_q + 8'd1;
      end
      DRAIN: begin
        state_d = WRITE;
        r_d     = '0;
      end
      WRITE: begin
        if (last_row) begin
          k_d = '0;
          r_d = '0;
          if (last_nt && last_mt) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            if (last_nt) begin
              nt_d = '0;
              mt_d = mt_q + 8'd1;
            end else begin
              nt_d = nt_q + 8'd1;
            end
          end
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from where the FSM is heading.
  always_comb begin
    busy_d    = (state_d != IDLE);
    a_index_d = '0;
    b_index_d = '0;
    c_wr_en_d = 1'b0;
    c_index_d = '0;
    c_data_d  = '0;
    if (state_d == LOAD) begin
      a_index_d = IDX_W'(mt_d) * IDX_W'(k_len) + IDX_W'(k_d);
      b_index_d = IDX_W'(nt_d) * IDX_W'(k_len) + IDX_W'(k_d);
    end
    if (state_d == WRITE) begin
      c_wr_en_d = 1'b1;
      c_index_d = IDX_W'(nt_d) * IDX_W'(m_len) + IDX_W'(mt_d) * IDX_W'(ARRAY) + IDX_W'(r_d);
      c_data_d  = row_data;
    end
  end

  // Output registers; everything clears on reset so a partial tile is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      a_index_q <= '0;
      b_index_q <= '0;
      c_wr_en_q <= 1'b0;
      c_index_q <= '0;
      c_data_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      a_index_q <= a_index_d;
      b_index_q <= b_index_d;
      c_wr_en_q <= c_wr_en_d;
      c_index_q <= c_index_d;
      c_data_q  <= c_data_d;
    end
  end

  tpu_mac_array #(
    .ARRAY  (ARRAY),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_q),
    .en_i        (en_q),
    .is_signed_i (sgn_q),
    .a_i         (bus.A_data_out),
    .b_i         (bus.B_data_out),
    .row_sel_i   (r_d),
    .row_o       (row_data)
  );

  assign bus.busy      = busy_q;
  assign bus.A_wr_en   = 1'b0;
  assign bus.A_index   = a_index_q;
  assign bus.A_data_in = '0;
  assign bus.B_wr_en   = 1'b0;
  assign bus.B_index   = b_index_q;
  assign bus.B_data_in = '0;
  assign bus.C_wr_en   = c_wr_en_q;
  assign bus.C_index   = c_index_q;
  assign bus.C_data_in = c_data_q;

endmodule

// File: tb/tb_tpu_gemm.sv
// tb/tb_tpu_gemm.sv - directed self-checking bench for tpu_gemm
module tb_tpu_gemm;
  import tpu_pkg::*;

  localparam int AR = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_gemm_if bus ();

  tpu_gemm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [AR*DW-1:0] a_mem [0:1023];
  logic [AR*DW-1:0] b_mem [0:1023];
  logic [AR*AW-1:0] c_mem [0:1023];
  bit               c_seen [0:1023];
  int               a_el [0:7][0:255];
  int               b_el [0:255][0:7];

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt, busy_cnt, first_wr, last_wr;
  bit done;
  bit wr_bad = 1'b0;
  logic [AR*AW-1:0] exp_w;

  assign bus.C_data_out = '0;

  // Buffer model with one-cycle synchronous read latency.
  always @(posedge clk) begin
    bus.A_data_out <= a_mem[bus.A_index[9:0]];
    bus.B_data_out <= b_mem[bus.B_index[9:0]];
  end

  always @(negedge clk) begin
    if (bus.A_wr_en || bus.B_wr_en || (|bus.A_data_in) || (|bus.B_data_in)) wr_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_el();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 256; k++) begin
        a_el[i][k] = 0;
        b_el[k][i] = 0;
      end
  endtask

  task automatic pack(input int k, input int m, input int n);
    int v;
    for (int w = 0; w < 1024; w++) begin
      a_mem[w] = '0;
      b_mem[w] = '0;
    end
    for (int mt = 0; mt * AR < m; mt++)
      for (int kk = 0; kk < k; kk++)
        for (int i = 0; i < AR; i++) begin
          v = (mt * AR + i < m) ? a_el[mt*AR+i][kk] : 0;
          a_mem[mt*k+kk][(AR-1-i)*DW +: DW] = v[7:0];
        end
    for (int nt = 0; nt * AR < n; nt++)
      for (int kk = 0; kk < k; kk++)
        for (int j = 0; j < AR; j++) begin
          v = (nt * AR + j < n) ? b_el[kk][nt*AR+j] : 0;
          b_mem[nt*k+kk][(AR-1-j)*DW +: DW] = v[7:0];
        end
  endtask

  task automatic run_job(input int k, input int m, input int n, input bit sgn, input int inject_at);
    for (int w = 0; w < 1024; w++) begin
      c_mem[w]  = '0;
      c_seen[w] = 1'b0;
    end
    wr_cnt = 0; busy_cnt = 0; first_wr = -1; last_wr = -1; done = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.K         = 8'(k);
    bus.M         = 8'(m);
    bus.N         = 8'(n);
    bus.is_signed = sgn;
    @(negedge clk);
    for (int cyc = 1; cyc < 5000; cyc++) begin
      if (cyc == inject_at) begin
        bus.in_valid = 1'b1;
        bus.K = 8'd1; bus.M = 8'd1; bus.N = 8'd1;
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.C_wr_en) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        c_mem[bus.C_index[9:0]]  = bus.C_data_in;
        c_seen[bus.C_index[9:0]] = 1'b1;
      end
      if (!bus.busy && !bus.C_wr_en) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("job_done", 128'(done), 128'd1);
  endtask

  task automatic setup_identity();
    clear_el();
    for (int i = 0; i < 4; i++) a_el[i][i] = 1;
    for (int kk = 0; kk < 4; kk++)
      for (int j = 0; j < 4; j++) b_el[kk][j] = kk * 4 + j;
    pack(4, 4, 4);
  endtask

  task automatic check_identity(input string pfx);
    for (int m = 0; m < 4; m++) begin
      exp_w = {32'(4*m), 32'(4*m+1), 32'(4*m+2), 32'(4*m+3)};
      check($sformatf("%s_c%0d", pfx, m), c_mem[m], exp_w);
    end
  endtask

  initial begin
    int sum;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.K = '0; bus.M = '0; bus.N = '0; bus.is_signed = 1'b0;
    for (int w = 0; w < 1024; w++) begin
      a_mem[w] = '0;
      b_mem[w] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy",    128'(bus.busy), 128'd0);
    check("rst_c_wr_en", 128'(bus.C_wr_en), 128'd0);
    check("rst_a_index", 128'(bus.A_index), 128'd0);
    check("rst_c_data",  128'(bus.C_data_in), 128'd0);
    rst = 1'b0;

    // Identity A, unsigned: C equals B, 4+1+4 cycle tile then DONE.
    setup_identity();
    run_job(4, 4, 4, 1'b0, 0);
    check("t1_wr_cnt",   128'(wr_cnt), 128'd4);
    check("t1_first_wr", 128'(first_wr), 128'd6);
    check("t1_last_wr",  128'(last_wr), 128'd9);
    check("t1_busy_cyc", 128'(busy_cnt), 128'd10);
    check_identity("t1");

    // Signed: 2 * (-1 * 127) = -254 in every lane.
    clear_el();
    for (int i = 0; i < 4; i++)
      for (int kk = 0; kk < 2; kk++) begin
        a_el[i][kk] = 255;
        b_el[kk][i] = 127;
      end
    pack(2, 4, 4);
    run_job(2, 4, 4, 1'b1, 0);
    check("t2_wr_cnt", 128'(wr_cnt), 128'd4);
    for (int m = 0; m < 4; m++)
      check($sformatf("t2_c%0d", m), c_mem[m], {4{32'hFFFFFF02}});

    // M/N tails with random unsigned data.
    clear_el();
    for (int kk = 0; kk < 3; kk++) begin
      for (int i = 0; i < 5; i++) a_el[i][kk] = int'($urandom_range(255));
      for (int j = 0; j < 6; j++) b_el[kk][j] = int'($urandom_range(255));
    end
    pack(3, 5, 6);
    run_job(3, 5, 6, 1'b0, 0);
    check("t3_wr_cnt", 128'(wr_cnt), 128'd10);
    for (int nt = 0; nt < 2; nt++)
      for (int m = 0; m < 5; m++) begin
        exp_w = '0;
        for (int j = 0; j < 4; j++) begin
          sum = 0;
          if (nt * 4 + j < 6)
            for (int kk = 0; kk < 3; kk++) sum += a_el[m][kk] * b_el[kk][nt*4+j];
          exp_w[(3-j)*32 +: 32] = 32'(sum);
        end
        check($sformatf("t3_seen%0d", nt*5+m), 128'(c_seen[nt*5+m]), 128'd1);
        check($sformatf("t3_c%0d", nt*5+m), c_mem[nt*5+m], exp_w);
      end

    // K = 0: one busy cycle, no writes.
    run_job(0, 4, 4, 1'b0, 0);
    check("t4_busy_cyc", 128'(busy_cnt), 128'd1);
    check("t4_wr_cnt",   128'(wr_cnt), 128'd0);

    // Start pulse during a running job is ignored.
    setup_identity();
    run_job(4, 4, 4, 1'b0, 3);
    check("t4b_busy_cyc", 128'(busy_cnt), 128'd10);
    check("t4b_wr_cnt",   128'(wr_cnt), 128'd4);
    check_identity("t4b");

    // Reset in the middle of LOAD.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.K = 8'd8; bus.M = 8'd4; bus.N = 8'd4; bus.is_signed = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_busy",  128'(bus.busy), 128'd1);
    check("t5_pre_index", 128'(bus.A_index), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy",    128'(bus.busy), 128'd0);
    check("t5_a_index", 128'(bus.A_index), 128'd0);
    check("t5_b_index", 128'(bus.B_index), 128'd0);
    check("t5_c_wr_en", 128'(bus.C_wr_en), 128'd0);
    check("t5_c_index", 128'(bus.C_index), 128'd0);
    rst = 1'b0;
    setup_identity();
    run_job(4, 4, 4, 1'b0, 0);
    check("t5_wr_cnt", 128'(wr_cnt), 128'd4);
    check_identity("t5");

    // Long unsigned job: 255 * 255 * 255 per lane.
    clear_el();
    for (int kk = 0; kk < 255; kk++)
      for (int i = 0; i < 4; i++) begin
        a_el[i][kk] = 255;
        b_el[kk][i] = 255;
      end
    pack(255, 4, 4);
    run_job(255, 4, 4, 1'b0, 0);
    check("t6_busy_cyc", 128'(busy_cnt), 128'd261);
    for (int m = 0; m < 4; m++)
      check($sformatf("t6_c%0d", m), c_mem[m], {4{32'd16581375}});

    check("ab_wr_never", 128'(wr_bad), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
